// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the writeback controller.
//   AW / DW    : default register address / data widths
//   REG_RA     : link register ($31), target of jal/jalr writes
//   REG_ZERO   : hard-wired zero register, never written or forwarded
//   wb_entry_t : one pending register write {valid, addr, data}
package cpu_pkg;
   localparam int AW = 5;
   localparam int DW = 32;

   localparam logic [AW-1:0] REG_RA   = 5'd31;
   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// Circular buffer of pending slow-path register writes.
// Each entry carries a valid bit so a younger ALU write can cancel it in
// place; cancelled entries still occupy their slot until they reach the head.
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   push_i, push_addr_i/_data_i   enqueue at tail (ignored when full)
//   pop_i                         dequeue head (ignored when empty)
//   squash_i, squash_addr_i       clear valid of every entry with that address,
//                                 including one pushed in the same cycle
//   head_valid_o/_addr_o/_data_o  current head entry
//   empty_o, full_o, count_o      occupancy
//   a_addr_i/b_addr_i -> *_hit_o/*_data_o  youngest valid entry matching address
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int AW    = 5
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [AW-1:0]              push_addr_i,
   input  logic [DW-1:0]              push_data_i,
   input  logic                       pop_i,
   input  logic                       squash_i,
   input  logic [AW-1:0]              squash_addr_i,
   output logic                       head_valid_o,
   output logic [AW-1:0]              head_addr_o,
   output logic [DW-1:0]              head_data_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     count_o,
   input  logic [AW-1:0]              a_addr_i,
   output logic                       a_hit_o,
   output logic [DW-1:0]              a_data_o,
   input  logic [AW-1:0]              b_addr_i,
   output logic                       b_hit_o,
   output logic [DW-1:0]              b_data_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [PW-1:0]    head_q, tail_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign head_valid_o = valid_q[head_q];
   assign head_addr_o  = addr_q[head_q];
   assign head_data_o  = data_q[head_q];

   // Scan oldest to youngest so the last match (youngest) wins.
   function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
      logic [DW:0]   r;
      logic [PW-1:0] idx;
      r = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if ((CW'(i) < count_q) && valid_q[idx] && (addr_q[idx] == a) && (a != '0))
            r = {1'b1, data_q[idx]};
      end
      return r;
   endfunction

   assign {a_hit_o, a_data_o} = lookup(a_addr_i);
   assign {b_hit_o, b_data_o} = lookup(b_addr_i);

   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (squash_i && (addr_q[i] == squash_addr_i))
            valid_d[i] = 1'b0;
      end
      // The ALU write is younger than a load accepted in the same cycle.
      if (do_push)
         valid_d[tail_q] = !(squash_i && (push_addr_i == squash_addr_i));
   end

   always_comb begin
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         if (do_push) tail_q <= tail_q + 1'b1;
         if (do_pop)  head_q <= head_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         addr_q[tail_q] <= push_addr_i;
         data_q[tail_q] <= push_data_i;
      end
   end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writer-side controller for the register file's single write port.
// Merges the never-stalled ALU result stream with the queued slow
// (load/multiply) results, cancels stale queued writes, and forwards
// pending data to the A/B read addresses being issued.
// Ports:
//   clk, rst (sync, active-low)
//   alu_valid/alu_addr/alu_link/alu_data   ALU result, always owns the port
//   ld_valid/ld_ready/ld_addr/ld_data      slow result handshake
//   w_addr/w_data/Reg_wr/ra_wr             registered regfile write port
//   A_addr/B_addr -> *_fwd_hit/*_fwd_data   forwarding lookup
//   pending                                occupied queue entries
module regfile_wb_ctrl #(
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int AW    = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alu_valid,
   input  logic [AW-1:0]          alu_addr,
   input  logic                   alu_link,
   input  logic [DW-1:0]          alu_data,
   input  logic                   ld_valid,
   output logic                   ld_ready,
   input  logic [AW-1:0]          ld_addr,
   input  logic [DW-1:0]          ld_data,
   output logic [AW-1:0]          w_addr,
   output logic [DW-1:0]          w_data,
   output logic                   Reg_wr,
   output logic                   ra_wr,
   input  logic [AW-1:0]          A_addr,
   input  logic [AW-1:0]          B_addr,
   output logic                   A_fwd_hit,
   output logic                   B_fwd_hit,
   output logic [DW-1:0]          A_fwd_data,
   output logic [DW-1:0]          B_fwd_data,
   output logic [$clog2(DEPTH):0] pending
);
   import cpu_pkg::*;

   logic          q_empty, q_full, q_head_valid;
   logic [AW-1:0] q_head_addr, alu_dst;
   logic [DW-1:0] q_head_data, qa_data, qb_data;
   logic          qa_hit, qb_hit, push, pop;

   logic [AW-1:0] w_addr_q, w_addr_d;
   logic [DW-1:0] w_data_q, w_data_d;
   logic          reg_wr_q, reg_wr_d, ra_wr_q, ra_wr_d;
   logic          wa_hit, wb_hit;

   // No pop-through credit: a full queue stalls even when it drains this cycle.
   assign ld_ready = !q_full && rst;
   assign push     = ld_valid && ld_ready;
   assign pop      = !alu_valid && !q_empty;
   assign alu_dst  = alu_link ? AW'(REG_RA) : alu_addr;

   wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_queue (
      .clk_i         (clk),
      .rst_ni        (rst),
      .push_i        (push),
      .push_addr_i   (ld_addr),
      .push_data_i   (ld_data),
      .pop_i         (pop),
      .squash_i      (alu_valid),
      .squash_addr_i (alu_dst),
      .head_valid_o  (q_head_valid),
      .head_addr_o   (q_head_addr),
      .head_data_o   (q_head_data),
      .empty_o       (q_empty),
      .full_o        (q_full),
      .count_o       (pending),
      .a_addr_i      (A_addr),
      .a_hit_o       (qa_hit),
      .a_data_o      (qa_data),
      .b_addr_i      (B_addr),
      .b_hit_o       (qb_hit),
      .b_data_o      (qb_data)
   );

   always_comb begin
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      reg_wr_d = 1'b0;
      ra_wr_d  = 1'b0;
      if (alu_valid) begin
         w_addr_d = alu_dst;
         w_data_d = alu_data;
         if (alu_link) ra_wr_d  = 1'b1;
         else          reg_wr_d = (alu_addr != AW'(REG_ZERO));
      end else if (!q_empty) begin
         // Squashed or $0 heads still pop, just without an enable.
         w_addr_d = q_head_addr;
         w_data_d = q_head_data;
         reg_wr_d = q_head_valid && (q_head_addr != AW'(REG_ZERO));
      end
   end

   // ---- write-port register stage ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         w_addr_q <= '0;
         w_data_q <= '0;
         reg_wr_q <= 1'b0;
         ra_wr_q  <= 1'b0;
      end else begin
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
         reg_wr_q <= reg_wr_d;
         ra_wr_q  <= ra_wr_d;
      end
   end

   assign w_addr = w_addr_q;
   assign w_data = w_data_q;
   assign Reg_wr = reg_wr_q;
   assign ra_wr  = ra_wr_q;

   // Queued data is younger than the write in flight, so it takes priority.
   assign wa_hit = (reg_wr_q || ra_wr_q) && (w_addr_q == A_addr) && (A_addr != AW'(REG_ZERO));
   assign wb_hit = (reg_wr_q || ra_wr_q) && (w_addr_q == B_addr) && (B_addr != AW'(REG_ZERO));

   assign A_fwd_hit  = qa_hit || wa_hit;
   assign B_fwd_hit  = qb_hit || wb_hit;
   assign A_fwd_data = qa_hit ? qa_data : (wa_hit ? w_data_q : '0);
   assign B_fwd_data = qb_hit ? qb_data : (wb_hit ? w_data_q : '0);
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;
   import cpu_pkg::*;

   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid, alu_link, ld_valid;
   logic [AW-1:0] alu_addr, ld_addr, A_addr, B_addr;
   logic [DW-1:0] alu_data, ld_data;
   logic          ld_ready, Reg_wr, ra_wr, A_fwd_hit, B_fwd_hit;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data, A_fwd_data, B_fwd_data;
   logic [$clog2(DEPTH):0] pending;

   typedef struct packed {
      logic      ra;
      wb_entry_t e;
   } wr_t;

   wr_t exp_q[$];
   int  vectors = 0;
   int  miscompares = 0;

   always #5 clk = ~clk;

   regfile_wb_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_addr   (alu_addr),
      .alu_link   (alu_link),
      .alu_data   (alu_data),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .Reg_wr     (Reg_wr),
      .ra_wr      (ra_wr),
      .A_addr     (A_addr),
      .B_addr     (B_addr),
      .A_fwd_hit  (A_fwd_hit),
      .B_fwd_hit  (B_fwd_hit),
      .A_fwd_data (A_fwd_data),
      .B_fwd_data (B_fwd_data),
      .pending    (pending)
   );

   function automatic wr_t mk(input logic ra, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t r;
      r.ra      = ra;
      r.e.valid = 1'b1;
      r.e.addr  = a;
      r.e.data  = d;
      return r;
   endfunction

   // Scoreboard: every regfile write must match the oldest expected write.
   always @(negedge clk) begin
      wr_t x;
      if (Reg_wr === 1'b1 || ra_wr === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write got addr=%0d data=%h reg_wr=%b ra_wr=%b, expected no write",
                     w_addr, w_data, Reg_wr, ra_wr);
         end else begin
            x = exp_q.pop_front();
            if (Reg_wr !== !x.ra || ra_wr !== x.ra || w_addr !== x.e.addr || w_data !== x.e.data) begin
               miscompares++;
               $display("FAIL write_port got reg_wr=%b ra_wr=%b addr=%0d data=%h, expected reg_wr=%b ra_wr=%b addr=%0d data=%h",
                        Reg_wr, ra_wr, w_addr, w_data, !x.ra, x.ra, x.e.addr, x.e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      alu_valid = 0; alu_link = 0; alu_addr = '0; alu_data = '0;
      ld_valid = 0; ld_addr = '0; ld_data = '0; A_addr = '0; B_addr = '0;
      repeat (3) step();
      vectors++;
      if (Reg_wr !== 1'b0 || ra_wr !== 1'b0 || w_addr !== '0 || w_data !== '0 || pending !== '0) begin
         miscompares++;
         $display("FAIL reset_state got reg_wr=%b ra_wr=%b addr=%0d data=%h pending=%0d, expected all 0",
                  Reg_wr, ra_wr, w_addr, w_data, pending);
      end
      vectors++;
      if (ld_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ld_ready got %b expected 0", ld_ready);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (ld_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_reset got %b expected 1", ld_ready);
      end
      step();
   endtask

   task automatic test_alu();
      alu_valid = 1; alu_addr = 5; alu_data = 32'h1234;
      exp_q.push_back(mk(1'b0, 5'd5, 32'h1234));
      step();
      alu_valid = 0;
      vectors++;
      if (Reg_wr !== 1'b1 || ra_wr !== 1'b0 || w_addr !== 5'd5 || w_data !== 32'h1234) begin
         miscompares++;
         $display("FAIL alu_latency got reg_wr=%b ra_wr=%b addr=%0d data=%h expected 1 0 5 00001234",
                  Reg_wr, ra_wr, w_addr, w_data);
      end
      A_addr = 5;
      #1;
      vectors++;
      if (A_fwd_hit !== 1'b1 || A_fwd_data !== 32'h1234) begin
         miscompares++;
         $display("FAIL fwd_write_stage got hit=%b data=%h expected 1 00001234", A_fwd_hit, A_fwd_data);
      end
      step();
      vectors++;
      if (Reg_wr !== 1'b0 || A_fwd_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL alu_pulse got reg_wr=%b a_hit=%b expected 0 0", Reg_wr, A_fwd_hit);
      end
      A_addr = 0;

      alu_valid = 1; alu_link = 1; alu_addr = 7; alu_data = 32'h400;
      exp_q.push_back(mk(1'b1, 5'd31, 32'h400));
      step();
      alu_valid = 0; alu_link = 0;
      vectors++;
      if (ra_wr !== 1'b1 || Reg_wr !== 1'b0 || w_addr !== 5'd31 || w_data !== 32'h400) begin
         miscompares++;
         $display("FAIL alu_link got ra_wr=%b reg_wr=%b addr=%0d data=%h expected 1 0 31 00000400",
                  ra_wr, Reg_wr, w_addr, w_data);
      end
      step();
      vectors++;
      if (ra_wr !== 1'b0) begin
         miscompares++;
         $display("FAIL link_pulse got ra_wr=%b expected 0", ra_wr);
      end

      alu_valid = 1; alu_addr = 0; alu_data = 32'hDEAD;
      step();
      alu_valid = 0;
      vectors++;
      if (Reg_wr !== 1'b0 || ra_wr !== 1'b0) begin
         miscompares++;
         $display("FAIL alu_zero got reg_wr=%b ra_wr=%b expected 0 0", Reg_wr, ra_wr);
      end
      step();
   endtask

   task automatic test_backpressure();
      int pend[5] = '{3, 3, 2, 1, 0};
      alu_valid = 1; alu_addr = 0; alu_data = 0;
      ld_valid = 1;
      for (int i = 1; i <= 4; i++) begin
         ld_addr = AW'(i); ld_data = 32'h100 + i;
         vectors++;
         if (ld_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_ready load=%0d got %b expected 1", i, ld_ready);
         end
         exp_q.push_back(mk(1'b0, AW'(i), 32'h100 + i));
         step();
      end
      ld_addr = 5; ld_data = 32'h105;
      step();
      vectors++;
      if (ld_ready !== 1'b0 || pending !== 4) begin
         miscompares++;
         $display("FAIL full_stall got ready=%b pending=%0d expected 0 4", ld_ready, pending);
      end
      exp_q.push_back(mk(1'b0, 5'd5, 32'h105));
      alu_valid = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 1) ld_valid = 0;
         vectors++;
         if (Reg_wr !== 1'b1 || w_addr !== AW'(k + 1) || pending !== pend[k]) begin
            miscompares++;
            $display("FAIL drain_%0d got reg_wr=%b addr=%0d pending=%0d expected 1 %0d %0d",
                     k, Reg_wr, w_addr, pending, k + 1, pend[k]);
         end
      end
      step();
      vectors++;
      if (Reg_wr !== 1'b0 || pending !== 0) begin
         miscompares++;
         $display("FAIL drain_idle got reg_wr=%b pending=%0d expected 0 0", Reg_wr, pending);
      end
   endtask

   task automatic test_squash();
      ld_valid = 1; ld_addr = 7; ld_data = 32'hAA;
      step();
      ld_valid = 0;
      alu_valid = 1; alu_addr = 7; alu_data = 32'hBB;
      exp_q.push_back(mk(1'b0, 5'd7, 32'hBB));
      step();
      alu_valid = 0;
      vectors++;
      if (pending !== 1 || w_data !== 32'hBB) begin
         miscompares++;
         $display("FAIL squash_hold got pending=%0d data=%h expected 1 000000bb", pending, w_data);
      end
      step();
      vectors++;
      if (Reg_wr !== 1'b0 || pending !== 0) begin
         miscompares++;
         $display("FAIL squash_pop got reg_wr=%b pending=%0d expected 0 0", Reg_wr, pending);
      end
      step();

      ld_valid = 1; ld_addr = 9; ld_data = 32'h99;
      alu_valid = 1; alu_addr = 9; alu_data = 32'h77;
      exp_q.push_back(mk(1'b0, 5'd9, 32'h77));
      step();
      ld_addr = 31; ld_data = 32'h31;
      alu_link = 1; alu_addr = 0; alu_data = 32'h500;
      exp_q.push_back(mk(1'b1, 5'd31, 32'h500));
      step();
      ld_valid = 0; alu_valid = 0; alu_link = 0;
      vectors++;
      if (pending !== 2) begin
         miscompares++;
         $display("FAIL same_cycle_pending got %0d expected 2", pending);
      end
      repeat (3) step();
      vectors++;
      if (pending !== 0 || Reg_wr !== 1'b0) begin
         miscompares++;
         $display("FAIL same_cycle_drain got pending=%0d reg_wr=%b expected 0 0", pending, Reg_wr);
      end
   endtask

   task automatic test_forward();
      alu_valid = 1; alu_addr = 0; alu_data = 0;
      ld_valid = 1; ld_addr = 3; ld_data = 32'h11;
      step();
      ld_data = 32'h22;
      step();
      ld_valid = 0;
      exp_q.push_back(mk(1'b0, 5'd3, 32'h11));
      exp_q.push_back(mk(1'b0, 5'd3, 32'h22));
      A_addr = 3; B_addr = 0;
      #1;
      vectors++;
      if (A_fwd_hit !== 1'b1 || A_fwd_data !== 32'h22) begin
         miscompares++;
         $display("FAIL fwd_youngest got hit=%b data=%h expected 1 00000022", A_fwd_hit, A_fwd_data);
      end
      vectors++;
      if (B_fwd_hit !== 1'b0 || B_fwd_data !== '0) begin
         miscompares++;
         $display("FAIL fwd_zero got hit=%b data=%h expected 0 0", B_fwd_hit, B_fwd_data);
      end
      B_addr = 4;
      #1;
      vectors++;
      if (B_fwd_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL fwd_miss got hit=%b expected 0", B_fwd_hit);
      end
      alu_valid = 0;
      step();
      vectors++;
      if (A_fwd_hit !== 1'b1 || A_fwd_data !== 32'h22) begin
         miscompares++;
         $display("FAIL fwd_queue_priority got hit=%b data=%h expected 1 00000022", A_fwd_hit, A_fwd_data);
      end
      step();
      vectors++;
      if (A_fwd_hit !== 1'b1 || A_fwd_data !== 32'h22 || pending !== 0) begin
         miscompares++;
         $display("FAIL fwd_after_drain got hit=%b data=%h pending=%0d expected 1 00000022 0",
                  A_fwd_hit, A_fwd_data, pending);
      end
      step();
      vectors++;
      if (A_fwd_hit !== 1'b0 || A_fwd_data !== '0) begin
         miscompares++;
         $display("FAIL fwd_idle got hit=%b data=%h expected 0 0", A_fwd_hit, A_fwd_data);
      end
      A_addr = 0; B_addr = 0;
   endtask

   task automatic test_reset_mid();
      alu_valid = 1; alu_addr = 0; alu_data = 0;
      ld_valid = 1;
      for (int i = 0; i < 3; i++) begin
         ld_addr = AW'(10 + i); ld_data = 32'hC0 + i;
         step();
      end
      vectors++;
      if (pending !== 3) begin
         miscompares++;
         $display("FAIL mid_pending got %0d expected 3", pending);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (ld_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_ready_low got %b expected 0", ld_ready);
      end
      step();
      alu_valid = 0;
      vectors++;
      if (pending !== 0 || Reg_wr !== 1'b0 || w_addr !== '0 || w_data !== '0) begin
         miscompares++;
         $display("FAIL mid_reset got pending=%0d reg_wr=%b addr=%0d data=%h expected 0 0 0 0",
                  pending, Reg_wr, w_addr, w_data);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (ld_ready !== 1'b0 || pending !== 0) begin
            miscompares++;
            $display("FAIL held_reset_%0d got ready=%b pending=%0d expected 0 0", i, ld_ready, pending);
         end
      end
      ld_valid = 0;
      rst = 1'b1;
      #1;
      vectors++;
      if (ld_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL release_ready got %b expected 1", ld_ready);
      end
      repeat (3) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu();
      test_backpressure();
      test_squash();
      test_forward();
      test_reset_mid();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_writes got %0d outstanding expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
